pipe_fetch_queue: RTL and testbench
===================================

# pipe_fetch_queue

Decoupling buffer between the instruction-fetch stage and the decode stage of the static 5-stage pipelined CPU. It replaces the plain IF/ID register. Each cycle it captures the fetched `inst` and `pc4` from fetch and presents the oldest entry to decode. It absorbs decode stalls without losing fetched words, and it discards all wrong-path entries when the PC is redirected by a branch, jump or jr.

## Interface
Parameters:
- `DEPTH`, default 2: number of entries; power of two, legal range 2..8.
- `AW`, default 1: pointer width, equal to log2(DEPTH).

Ports:
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high; sampled on the rising edge of `clock`.
- `f_valid`, input, 1: fetch presents a valid `f_inst`/`f_pc4` this cycle.
- `f_inst`, input, 32: fetched instruction word.
- `f_pc4`, input, 32: fetched PC + 4.
- `redirect`, input, 1: flush; asserted when `pcsource[1:0] != 0` takes effect in decode.
- `d_ready`, input, 1: decode accepts the head entry this cycle (the inverse of the decode stall).
- `f_ready`, output, 1: queue can accept a word; drives the PC register write enable.
- `d_valid`, output, 1: head entry is valid.
- `d_inst`, output, 32: head instruction; 32'h0000_0000 (nop) when `d_valid` = 0.
- `d_pc4`, output, 32: head PC + 4; 32'h0 when `d_valid` = 0.
- `count`, output, AW+1: number of occupied entries, 0..DEPTH.

## Operation
Storage and pointers:
- Circular buffer of DEPTH entries, each holding a 64-bit {inst, pc4} pair.
- Write pointer `wp`, read pointer `rp`, and occupancy `count`.
- `wp` and `rp` wrap modulo DEPTH.

Control terms:
- `push` = `f_valid` & `f_ready` & ~`redirect`.
- `pop` = `d_valid` & `d_ready` & ~`redirect`.
- `f_ready` = (`count` < DEPTH). It depends on `count` only, not on `d_ready`. A full queue refuses a push even when a pop happens in the same cycle.
- `d_valid` = (`count` != 0). `d_inst`/`d_pc4` = entry[`rp`] when `d_valid`, zero otherwise.

Per-cycle update, highest priority first:
1. `reset`: `wp` = 0, `rp` = 0, `count` = 0. Storage contents are don't-care.
2. `redirect`: `wp` = 0, `rp` = 0, `count` = 0. The word fetched in the same cycle is wrong-path and is dropped.
3. Otherwise:
   - `push` only: write entry[`wp`], increment `wp`, increment `count`.
   - `pop` only: increment `rp`, decrement `count`.
   - Both: write and read at different slots; both pointers advance; `count` is unchanged.
   - Neither: hold all state.

Boundary rules:
- Empty with simultaneous `push` and `d_ready`: no pop, because `d_valid` = 0. There is no fall-through; the word appears at the output the next cycle.
- `count` never exceeds DEPTH and never underflows. An assertion in the bench checks this.
- `redirect` during `reset`: reset wins; the result is identical in either case.
- `f_inst`/`f_pc4` are ignored whenever `push` = 0.

## Timing
- Latency: a word pushed at edge N is visible on `d_inst`/`d_pc4` after edge N, provided the queue was empty.
- Throughput: 1 word per cycle in steady state when `d_ready` = 1 and `count` < DEPTH.
- All outputs are functions of registered state only. There is no combinational path from any input to any output, which breaks the stall→PC-enable loop.
- After reset, all outputs are: `f_ready` = 1, `d_valid` = 0, `d_inst` = 0, `d_pc4` = 0, `count` = 0.
- After `redirect`, all outputs take their reset values on the following cycle. The first correct-path word arrives one cycle later.
- Storage uses plain registers; no memory macro is required.

## Test plan
- Reset then stream: `f_valid` = 1, `d_ready` = 1, words 0x20010001/pc4 0x4 and 0x20020002/0x8 on consecutive cycles. Expect `d_inst` = 0x20010001 one cycle after the first push, then 0x20020002 on the next cycle, with `count` holding at 1.
- Fill on stall, DEPTH = 2: `d_ready` = 0, push A, B, C. Expect `count` = 2, `f_ready` = 0, C not captured, and `d_inst` = A throughout. Then release with `d_ready` = 1: expect A, then B, then `d_valid` = 0.
- Full plus simultaneous pop: `count` = 2, `d_ready` = 1, `f_valid` = 1. Expect the pop only, `count` = 1, and `f_ready` = 1 on the next cycle.
- Redirect mid-stream: `count` = 2, assert `redirect` with `f_valid` = 1. Next cycle expect `count` = 0, `d_inst` = 0, `d_valid` = 0, and the fetched word dropped. The following push appears normally.
- Wrap-around: DEPTH = 4, 11 pushes with random `d_ready`. Output order must equal input order, with no loss and no duplication; compare against a scoreboard.
- Reset mid-operation: with `count` = 3 and `redirect` = 1, assert `reset`. Expect all outputs at their reset values next cycle, and `f_ready` = 1.

Source files
------------

// File: rtl/pipe_fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// The slave modport is the queue's view; the master modport is the pipeline side.
interface pipe_fetch_queue_if #(
  parameter int AW = 1
);
  logic          f_valid;
  logic [31:0]   f_inst;
  logic [31:0]   f_pc4;
  logic          redirect;
  logic          d_ready;
  logic          f_ready;
  logic          d_valid;
  logic [31:0]   d_inst;
  logic [31:0]   d_pc4;
  logic [AW:0]   count;

  modport slave (
    input  f_valid, f_inst, f_pc4, redirect, d_ready,
    output f_ready, d_valid, d_inst, d_pc4, count
  );

  modport master (
    output f_valid, f_inst, f_pc4, redirect, d_ready,
    input  f_ready, d_valid, d_inst, d_pc4, count
  );
endinterface

// File: rtl/pipe_fetch_queue.sv
// Circular fetch-to-decode queue replacing the IF/ID register; absorbs decode
// stalls and flushes wrong-path words on redirect. Outputs depend on registered state only.
module pipe_fetch_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input logic              clock,
  input logic              reset,
  pipe_fetch_queue_if.slave fq
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          push;
  logic          pop;

  // f_ready looks only at occupancy so the PC enable never sees d_ready.
  assign fq.f_ready = (count_q < FULL);
  assign fq.d_valid = (count_q != '0);
  assign fq.d_inst  = fq.d_valid ? mem_q[rp_q][63:32] : 32'h0;
  assign fq.d_pc4   = fq.d_valid ? mem_q[rp_q][31:0]  : 32'h0;
  assign fq.count   = count_q;

  assign push = fq.f_valid & fq.f_ready & ~fq.redirect;
  assign pop  = fq.d_valid & fq.d_ready & ~fq.redirect;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (fq.redirect) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wp_d = wp_q + AW'(1);
      end
      if (pop) begin
        rp_d = rp_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + (AW+1)'(1);
      end else if (pop && !push) begin
        count_d = count_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; d_valid masks stale contents.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wp_q] <= {fq.f_inst, fq.f_pc4};
    end
  end

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Directed bench for pipe_fetch_queue: a DEPTH=2 instance for stream/stall/flush
// cases and a DEPTH=4 instance for wrap-around order and reset during redirect.
module tb_pipe_fetch_queue;

  logic clock;
  logic reset;
  int   assertCount;
  int   failCount;

  pipe_fetch_queue_if #(.AW(1)) qa ();
  pipe_fetch_queue_if #(.AW(2)) qb ();

  pipe_fetch_queue #(.DEPTH(2), .AW(1)) dutA (
    .clock (clock),
    .reset (reset),
    .fq    (qa.slave)
  );

  pipe_fetch_queue #(.DEPTH(4), .AW(2)) dutB (
    .clock (clock),
    .reset (reset),
    .fq    (qb.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic fv, input logic [31:0] inst, input logic [31:0] pc4,
                               input logic redir, input logic dr);
    qa.f_valid  = fv;
    qa.f_inst   = inst;
    qa.f_pc4    = pc4;
    qa.redirect = redir;
    qa.d_ready  = dr;
  endtask

  task automatic applyStimulusB(input logic fv, input logic [31:0] inst, input logic [31:0] pc4,
                                input logic redir, input logic dr);
    qb.f_valid  = fv;
    qb.f_inst   = inst;
    qb.f_pc4    = pc4;
    qb.redirect = redir;
    qb.d_ready  = dr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkA(input string tag, input logic fr, input logic dv,
                        input logic [31:0] inst, input logic [31:0] pc4, input int cnt);
    checkOutput({tag, "_f_ready"}, 64'(qa.f_ready), 64'(fr));
    checkOutput({tag, "_d_valid"}, 64'(qa.d_valid), 64'(dv));
    checkOutput({tag, "_d_inst"},  64'(qa.d_inst),  64'(inst));
    checkOutput({tag, "_d_pc4"},   64'(qa.d_pc4),   64'(pc4));
    checkOutput({tag, "_count"},   64'(qa.count),   64'(cnt));
  endtask

  initial begin
    logic [63:0] sb[$];
    int pushed;
    int popped;
    int modelCount;
    int cycles;
    logic modelPush;
    logic modelPop;
    logic drRand;

    assertCount = 0;
    failCount   = 0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulusB(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    checkA("reset", 1'b1, 1'b0, 32'h0, 32'h0, 0);

    // Stream two words back-to-back with decode always ready.
    applyStimulus(1'b1, 32'h2001_0001, 32'h4, 1'b0, 1'b1);
    step();
    checkA("stream1", 1'b1, 1'b1, 32'h2001_0001, 32'h4, 1);
    applyStimulus(1'b1, 32'h2002_0002, 32'h8, 1'b0, 1'b1);
    step();
    checkA("stream2", 1'b1, 1'b1, 32'h2002_0002, 32'h8, 1);
    applyStimulus(1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b0, 1'b1);
    step();
    checkA("drain", 1'b1, 1'b0, 32'h0, 32'h0, 0);

    // Fill while decode stalls; third word must be refused.
    applyStimulus(1'b1, 32'hAAAA_0001, 32'h10, 1'b0, 1'b0);
    step();
    checkA("fillA", 1'b1, 1'b1, 32'hAAAA_0001, 32'h10, 1);
    applyStimulus(1'b1, 32'hBBBB_0002, 32'h14, 1'b0, 1'b0);
    step();
    checkA("fillB", 1'b0, 1'b1, 32'hAAAA_0001, 32'h10, 2);
    applyStimulus(1'b1, 32'hCCCC_0003, 32'h18, 1'b0, 1'b0);
    step();
    checkA("fillC", 1'b0, 1'b1, 32'hAAAA_0001, 32'h10, 2);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    checkA("releaseB", 1'b1, 1'b1, 32'hBBBB_0002, 32'h14, 1);
    step();
    checkA("releaseEnd", 1'b1, 1'b0, 32'h0, 32'h0, 0);

    // Full queue with simultaneous fetch and pop: only the pop happens.
    applyStimulus(1'b1, 32'h1111_0001, 32'h20, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h2222_0002, 32'h24, 1'b0, 1'b0);
    step();
    checkA("fullPre", 1'b0, 1'b1, 32'h1111_0001, 32'h20, 2);
    applyStimulus(1'b1, 32'h3333_0003, 32'h28, 1'b0, 1'b1);
    step();
    checkA("fullPop", 1'b1, 1'b1, 32'h2222_0002, 32'h24, 1);

    // Redirect with two entries and a fetched word: everything discarded.
    applyStimulus(1'b1, 32'h4444_0004, 32'h2C, 1'b0, 1'b0);
    step();
    checkA("redirPre", 1'b0, 1'b1, 32'h2222_0002, 32'h24, 2);
    applyStimulus(1'b1, 32'h5555_0005, 32'h30, 1'b1, 1'b1);
    step();
    checkA("redirect", 1'b1, 1'b0, 32'h0, 32'h0, 0);
    applyStimulus(1'b1, 32'h6666_0006, 32'h34, 1'b0, 1'b0);
    step();
    checkA("postRedir", 1'b1, 1'b1, 32'h6666_0006, 32'h34, 1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Wrap-around on the DEPTH=4 instance against a scoreboard.
    pushed     = 0;
    popped     = 0;
    modelCount = 0;
    cycles     = 0;
    while (popped < 11 && cycles < 300) begin
      drRand = 1'($urandom_range(0, 1));
      applyStimulusB(pushed < 11, 32'h7000_0000 + 32'(pushed), 32'(pushed * 4 + 4), 1'b0, drRand);
      modelPush = (pushed < 11) && (modelCount < 4);
      modelPop  = (modelCount != 0) && drRand;
      checkOutput("wrap_count", 64'(qb.count), 64'(modelCount));
      checkOutput("wrap_bound", 64'(qb.count <= 3'd4), 64'd1);
      if (modelPop) begin
        checkOutput("wrap_order", {qb.d_inst, qb.d_pc4}, sb[0]);
        void'(sb.pop_front());
        popped++;
      end
      if (modelPush) begin
        sb.push_back({32'h7000_0000 + 32'(pushed), 32'(pushed * 4 + 4)});
        pushed++;
      end
      modelCount = modelCount + (modelPush ? 1 : 0) - (modelPop ? 1 : 0);
      step();
      cycles++;
    end
    checkOutput("wrap_popped", 64'(popped), 64'd11);
    checkOutput("wrap_empty_valid", 64'(qb.d_valid), 64'd0);

    // Three entries, then reset together with redirect.
    applyStimulusB(1'b1, 32'h8000_0001, 32'h40, 1'b0, 1'b0);
    step();
    applyStimulusB(1'b1, 32'h8000_0002, 32'h44, 1'b0, 1'b0);
    step();
    applyStimulusB(1'b1, 32'h8000_0003, 32'h48, 1'b0, 1'b0);
    step();
    checkOutput("midReset_pre_count", 64'(qb.count), 64'd3);
    checkOutput("midReset_pre_inst", 64'(qb.d_inst), 64'h8000_0001);
    applyStimulusB(1'b1, 32'h9000_0009, 32'h4C, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    applyStimulusB(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checkOutput("midReset_f_ready", 64'(qb.f_ready), 64'd1);
    checkOutput("midReset_d_valid", 64'(qb.d_valid), 64'd0);
    checkOutput("midReset_d_inst",  64'(qb.d_inst),  64'd0);
    checkOutput("midReset_d_pc4",   64'(qb.d_pc4),   64'd0);
    checkOutput("midReset_count",   64'(qb.count),   64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
